// File: rtl/bcd_display_scanner.sv
// Latches three BCD digits and scans them onto a 4-digit common-anode 7-segment display.
// Outputs are registered from next-state values, so they track the current state with no lag.
module bcd_display_scanner #(
  parameter int REFRESH_COUNT = 100000,
  parameter int GUARD         = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [1:0] digit_sel
);

  localparam int CW = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_COUNT - 1);
  localparam logic [CW-1:0] GUARD_LEN = CW'(GUARD);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    sel_nxt;
  logic [3:0]    hund_q, tens_q, ones_q;
  logic [3:0]    hund_nxt, tens_nxt, ones_nxt;
  logic [3:0]    digit_nxt;
  logic          blank_nxt;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    sel_nxt = digit_sel;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      sel_nxt = (digit_sel >= 2'd2) ? 2'd0 : digit_sel + 2'd1;
    end
  end

  always_comb begin
    hund_nxt = hund_q;
    tens_nxt = tens_q;
    ones_nxt = ones_q;
    if (load) begin
      hund_nxt = hundreds;
      tens_nxt = tens;
      ones_nxt = ones;
    end
  end

  // Decode from next-state values so the registered outputs line up with the state they describe.
  always_comb begin
    digit_nxt = ones_nxt;
    blank_nxt = 1'b0;
    case (sel_nxt)
      2'd1: begin
        digit_nxt = tens_nxt;
        blank_nxt = (BLANK_LEADING != 0) && (hund_nxt == 4'd0) && (tens_nxt == 4'd0);
      end
      2'd2: begin
        digit_nxt = hund_nxt;
        blank_nxt = (BLANK_LEADING != 0) && (hund_nxt == 4'd0);
      end
      default: begin
        digit_nxt = ones_nxt;
        blank_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'h7F;
    if (!(cnt_nxt < GUARD_LEN) && !blank_nxt) begin
      an_nxt    = ~(4'b0001 << sel_nxt);
      an_nxt[3] = 1'b1;
      seg_nxt   = decode(digit_nxt);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      digit_sel <= 2'd0;
      hund_q    <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      an        <= 4'b1111;
      seg       <= 7'h7F;
    end else begin
      cnt       <= cnt_nxt;
      digit_sel <= sel_nxt;
      hund_q    <= hund_nxt;
      tens_q    <= tens_nxt;
      ones_q    <= ones_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench: two scanners (leading-zero blanking on / off) driven by the same stimulus.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] hundreds, tens, ones;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       dp_a, dp_b;
  logic [1:0] sel_a, sel_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(.REFRESH_COUNT(8), .GUARD(2), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .reset(reset), .load(load),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .seg(seg_a), .an(an_a), .dp(dp_a), .digit_sel(sel_a)
  );

  bcd_display_scanner #(.REFRESH_COUNT(8), .GUARD(2), .BLANK_LEADING(0)) dut_b (
    .clk(clk), .reset(reset), .load(load),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .seg(seg_b), .an(an_b), .dp(dp_b), .digit_sel(sel_b)
  );

  // obs/exp layout: {sel_a, sel_b, an_a, seg_a, an_b, seg_b, dp_a, dp_b}
  task automatic chk(input string tag, input logic [1:0] sel,
                     input logic [3:0] ea, input logic [6:0] sa,
                     input logic [3:0] eb, input logic [6:0] sb);
    logic [27:0] obs, exp;
    obs = {sel_a, sel_b, an_a, seg_a, an_b, seg_b, dp_a, dp_b};
    exp = {sel, sel, ea, sa, eb, sb, 1'b1, 1'b1};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One 8-cycle slot: 2 guard cycles then 6 active; optional load on the wrap edge.
  task automatic slot(input string tag, input logic [1:0] sel,
                      input logic [3:0] ea, input logic [6:0] sa,
                      input logic [3:0] eb, input logic [6:0] sb,
                      input bit ld_last);
    for (int i = 0; i < 8; i++) begin
      load = ld_last && (i == 7);
      if (i < 2) chk({tag, "_guard"}, sel, 4'hF, 7'h7F, 4'hF, 7'h7F);
      else       chk(tag, sel, ea, sa, eb, sb);
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    hundreds = 4'd0;
    tens     = 4'd0;
    ones     = 4'd0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", 2'd0, 4'hF, 7'h7F, 4'hF, 7'h7F);
    end
    reset = 1'b0;

    slot("zero_ones", 2'd0, 4'hE, 7'h40, 4'hE, 7'h40, 1'b0);
    slot("zero_tens", 2'd1, 4'hF, 7'h7F, 4'hD, 7'h40, 1'b0);
    {hundreds, tens, ones} = {4'd2, 4'd5, 4'd5};
    slot("zero_hund", 2'd2, 4'hF, 7'h7F, 4'hB, 7'h40, 1'b1);

    // Inputs change mid-scan without load; display must hold 2/5/5.
    {hundreds, tens, ones} = {4'd0, 4'd0, 4'd7};
    for (int k = 0; k < 2; k++) begin
      slot("v255_ones", 2'd0, 4'hE, 7'h12, 4'hE, 7'h12, 1'b0);
      slot("v255_tens", 2'd1, 4'hD, 7'h12, 4'hD, 7'h12, 1'b0);
      slot("v255_hund", 2'd2, 4'hB, 7'h24, 4'hB, 7'h24, k == 1);
    end

    slot("v007_ones", 2'd0, 4'hE, 7'h78, 4'hE, 7'h78, 1'b0);
    slot("v007_tens", 2'd1, 4'hF, 7'h7F, 4'hD, 7'h40, 1'b0);
    {hundreds, tens, ones} = {4'd0, 4'd4, 4'd0};
    slot("v007_hund", 2'd2, 4'hF, 7'h7F, 4'hB, 7'h40, 1'b1);

    slot("v040_ones", 2'd0, 4'hE, 7'h40, 4'hE, 7'h40, 1'b0);
    slot("v040_tens", 2'd1, 4'hD, 7'h19, 4'hD, 7'h19, 1'b0);
    {hundreds, tens, ones} = {4'd1, 4'd0, 4'hC};
    slot("v040_hund", 2'd2, 4'hF, 7'h7F, 4'hB, 7'h40, 1'b1);

    slot("v10c_ones", 2'd0, 4'hE, 7'h3F, 4'hE, 7'h3F, 1'b0);
    slot("v10c_tens", 2'd1, 4'hD, 7'h40, 4'hD, 7'h40, 1'b0);
    slot("v10c_hund", 2'd2, 4'hB, 7'h79, 4'hB, 7'h79, 1'b0);

    // Load 9/9/9 on the tens->hundreds wrap edge.
    {hundreds, tens, ones} = {4'd9, 4'd9, 4'd9};
    slot("v10c_ones2", 2'd0, 4'hE, 7'h3F, 4'hE, 7'h3F, 1'b0);
    slot("wrapld_tens", 2'd1, 4'hD, 7'h40, 4'hD, 7'h40, 1'b1);
    slot("wrapld_hund", 2'd2, 4'hB, 7'h10, 4'hB, 7'h10, 1'b0);
    slot("v999_ones", 2'd0, 4'hE, 7'h10, 4'hE, 7'h10, 1'b0);

    {hundreds, tens, ones} = {4'd3, 4'd3, 4'd3};
    for (int i = 0; i < 5; i++) begin
      if (i < 2) chk("v999_tens_guard", 2'd1, 4'hF, 7'h7F, 4'hF, 7'h7F);
      else       chk("v999_tens", 2'd1, 4'hD, 7'h10, 4'hD, 7'h10);
      @(negedge clk);
    end
    chk("pre_reset_cnt5", 2'd1, 4'hD, 7'h10, 4'hD, 7'h10);
    reset = 1'b1;
    #1;
    chk("async_reset", 2'd0, 4'hF, 7'h7F, 4'hF, 7'h7F);
    @(negedge clk);
    chk("reset_held", 2'd0, 4'hF, 7'h7F, 4'hF, 7'h7F);
    reset = 1'b0;

    slot("post_rst_ones", 2'd0, 4'hE, 7'h40, 4'hE, 7'h40, 1'b0);
    slot("post_rst_tens", 2'd1, 4'hF, 7'h7F, 4'hD, 7'h40, 1'b0);
    slot("post_rst_hund", 2'd2, 4'hF, 7'h7F, 4'hB, 7'h40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the binary-to-BCD converter's Hundreds/Tens/Ones nibbles.
- Latches the three BCD digits on a load strobe.
- Time-multiplexes them onto a 4-digit common-anode 7-segment display: one anode at a time, refresh divider, leading-zero blanking, anti-ghosting guard interval.
- Anode 3 is unused and always off.

Parameters:
- REFRESH_COUNT, 100000: clock cycles per digit slot. Minimum 2. Default gives 1 ms per slot at 100 MHz.
- GUARD, 4: cycles at the start of each slot with all anodes off. Must be < REFRESH_COUNT.
- BLANK_LEADING, 1: 1 = blank leading zeros in the hundreds and tens digits; 0 = show all digits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  latch strobe; samples the three digit inputs on the rising edge where load=1.
- hundreds  in  4  BCD hundreds digit.
- tens  in  4  BCD tens digit.
- ones  in  4  BCD ones digit.
- seg  out  7  segment cathodes, active low, seg[6:0]=g,f,e,d,c,b,a.
- an  out  4  digit anodes, active low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3] always 1.
- dp  out  1  decimal point, active low; constant 1 (off).
- digit_sel  out  2  current slot index: 0=ones, 1=tens, 2=hundreds.

Behaviour:
- Reset (async, immediate, including mid-slot):
  - cnt=0, digit_sel=0, latched digits=0.
  - an=4'b1111, seg=7'h7F, dp=1.
- Divider:
  - cnt increments every cycle.
  - At cnt==REFRESH_COUNT-1: cnt wraps to 0 and digit_sel advances 0->1->2->0. digit_sel never takes value 3.
  - Full scan period = 3*REFRESH_COUNT cycles.
- Load:
  - On an edge with load=1, the latched hundreds/tens/ones take the input values.
  - Inputs are ignored when load=0.
  - load coinciding with a wrap: both take effect on the same edge; the new slot shows the new value.
- Outputs:
  - an and seg are registers loaded from next-state values of cnt/digit_sel/latched digits.
  - Net effect: they always match the current state with zero added lag. A load at edge k is visible on seg from edge k.
- Guard: while cnt < GUARD, an=4'b1111 and seg=7'h7F.
- Active part of slot (cnt >= GUARD):
  - Anode for digit_sel driven 0, all others 1.
  - seg = decode(latched digit), unless that digit is blanked.
- Blanking (only when BLANK_LEADING=1):
  - Hundreds is blanked when latched hundreds==0.
  - Tens is blanked when latched hundreds==0 and latched tens==0.
  - Ones is never blanked.
  - A blanked digit gives an=4'b1111 and seg=7'h7F for its whole slot.
  - Slot timing is unchanged by blanking; no slot is skipped.
- Decode (active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Invalid nibble 10..15 gives dash 7'h3F (segment g only).
  - An invalid hundreds nibble is nonzero, so it is never blanked.

Test Plan:
(Bench uses REFRESH_COUNT=8, GUARD=2.)
- Reset:
  - Hold reset 3 cycles -> an=F, seg=7F, dp=1, digit_sel=0 throughout.
  - After release, an=F for cycles 0-1, then the ones digit (latched 0) shows an=E, seg=40.
- Load 2/5/5:
  - Ones slot: an=E, seg=12.
  - Tens slot: an=D, seg=12.
  - Hundreds slot: an=B, seg=24.
  - Each slot has 2 guard cycles (an=F) and 6 active cycles.
  - Pattern repeats every 24 cycles.
- Load 0/0/7, BLANK_LEADING=1:
  - Ones: an=E, seg=78.
  - Tens and hundreds slots: an=F, seg=7F for all 8 cycles.
  - Same load with BLANK_LEADING=0: tens and hundreds show seg=40 on an=D and an=B.
- Load 0/4/0:
  - Hundreds blanked.
  - Tens: an=D, seg=19.
  - Ones: an=E, seg=40 (interior/trailing zeros are not blanked).
- Load ones=4'hC, hundreds=1, tens=0:
  - Ones shows seg=3F.
  - Tens shows seg=40 (not blanked, because hundreds is nonzero).
- Boundaries:
  - Load 9/9/9 on the wrap edge from tens to hundreds -> hundreds slot first active cycle shows seg=10.
  - Assert reset at cnt=5 of the tens slot -> an=F, seg=7F immediately, before the next clock edge; the scan restarts at the ones slot with latched 0.
